// File: rtl/fb_cell_painter_pkg.sv
// Shared constants, op/state encodings and the cell base-address helper for the
// framebuffer cell painter. Full-screen clear is built only when FB_CLEAR_EN is defined.
package fb_pkg;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int CELL   = 8;
  localparam int GRID_W = FB_W / CELL;
  localparam int GRID_H = FB_H / CELL;
  localparam int ADDR_W = 22;
  localparam int CELL_W = $clog2(CELL);
  localparam int FB_PIX = FB_W * FB_H;

  // Jump from the last pixel of one cell row to the first pixel of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W - CELL + 1);

  typedef enum logic [1:0] {
    OP_CELL  = 2'd0,
    OP_CLEAR = 2'd1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CELL  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Top-left pixel address of a grid cell; evaluated once per accepted command.
  function automatic logic [ADDR_W-1:0] cell_base(input logic [5:0] cx, input logic [4:0] cy);
    return ADDR_W'(cy) * ADDR_W'(CELL * FB_W) + ADDR_W'(cx) * ADDR_W'(CELL);
  endfunction

endpackage

// File: rtl/fb_cell_painter_if.sv
// Command and memory-write bundle of the cell painter; slave is the engine's view,
// master the view of the game logic plus the s1 memory port.
interface fb_cell_painter_if;
  import fb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [5:0]        cmd_cx;
  logic [4:0]        cmd_cy;
  logic [15:0]       cmd_color;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;
  logic [15:0]       mem_writedata;
  logic [1:0]        mem_byteenable;
  logic              mem_debugaccess;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_cx, cmd_cy, cmd_color,
    output cmd_ready, mem_address, mem_chipselect, mem_write, mem_clken,
    output mem_writedata, mem_byteenable, mem_debugaccess, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_cx, cmd_cy, cmd_color,
    input  cmd_ready, mem_address, mem_chipselect, mem_write, mem_clken,
    input  mem_writedata, mem_byteenable, mem_debugaccess, busy, done, err
  );

endinterface

// File: rtl/fb_cell_painter_addr_gen.sv
// Incremental pixel address generator: px/py walk inside a cell, or a plain linear
// sweep of the framebuffer when FB_CLEAR_EN is defined (mode=1).
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_r;
  logic [CELL_W-1:0] px_r;
  logic [CELL_W-1:0] py_r;
  logic              row_end_s;
  logic              cell_last_s;

  assign row_end_s   = (px_r == CELL_W'(CELL - 1));
  assign cell_last_s = row_end_s && (py_r == CELL_W'(CELL - 1));
  assign addr        = addr_r;

`ifdef FB_CLEAR_EN
  logic mode_r;

  // Address, pixel counters and sweep mode, reloaded at each accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      px_r   <= {CELL_W{1'b0}};
      py_r   <= {CELL_W{1'b0}};
      mode_r <= 1'b0;
    end else if (load) begin
      addr_r <= base;
      px_r   <= {CELL_W{1'b0}};
      py_r   <= {CELL_W{1'b0}};
      mode_r <= mode;
    end else if (adv && mode_r) begin
      addr_r <= addr_r + ADDR_W'(1);
    end else if (adv && row_end_s) begin
      addr_r <= addr_r + step;
      px_r   <= {CELL_W{1'b0}};
      py_r   <= py_r + CELL_W'(1);
    end else if (adv) begin
      addr_r <= addr_r + ADDR_W'(1);
      px_r   <= px_r + CELL_W'(1);
    end
  end

  assign last = mode_r ? (addr_r == ADDR_W'(FB_PIX - 1)) : cell_last_s;
`else
  logic unused_mode_s;
  assign unused_mode_s = mode;

  // Address and pixel counters for the cell walk, reloaded at each accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      px_r   <= {CELL_W{1'b0}};
      py_r   <= {CELL_W{1'b0}};
    end else if (load) begin
      addr_r <= base;
      px_r   <= {CELL_W{1'b0}};
      py_r   <= {CELL_W{1'b0}};
    end else if (adv && row_end_s) begin
      addr_r <= addr_r + step;
      px_r   <= {CELL_W{1'b0}};
      py_r   <= py_r + CELL_W'(1);
    end else if (adv) begin
      addr_r <= addr_r + ADDR_W'(1);
      px_r   <= px_r + CELL_W'(1);
    end
  end

  assign last = cell_last_s;
`endif

endmodule

// File: rtl/fb_cell_painter.sv
// Framebuffer write engine: turns cell-paint / clear commands into single-cycle
// writes on the memory s1 port. Full-screen clear requires FB_CLEAR_EN.
module fb_cell_painter
  import fb_pkg::*;
(
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  fb_cell_painter_if.slave bus
);

  state_e            state_r;
  state_e            state_n_s;
  logic              cmd_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic              wr_r;
  logic              clken_r;
  logic [15:0]       wdata_r;
  logic [1:0]        be_r;
  logic              accept_s;
  logic              cell_ok_s;
  logic              load_s;
  logic              adv_s;
  logic              mode_s;
  logic              done_n_s;
  logic              err_n_s;
  logic              last_s;
  logic [ADDR_W-1:0] base_s;
  logic [ADDR_W-1:0] addr_s;

  assign accept_s  = bus.cmd_valid && cmd_ready_r;
  assign cell_ok_s = (bus.cmd_cx < 6'(GRID_W)) && (bus.cmd_cy < 5'(GRID_H));

  // Next-state decode: command acceptance, legality check and burst termination.
  always_comb begin
    state_n_s = state_r;
    load_s    = 1'b0;
    adv_s     = 1'b0;
    mode_s    = 1'b0;
    done_n_s  = 1'b0;
    err_n_s   = 1'b0;
    base_s    = cell_base(bus.cmd_cx, bus.cmd_cy);
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_n_s = ST_IDLE;
        end else if ((bus.cmd_op == OP_CELL) && cell_ok_s) begin
          state_n_s = ST_CELL;
          load_s    = 1'b1;
`ifdef FB_CLEAR_EN
        end else if (bus.cmd_op == OP_CLEAR) begin
          state_n_s = ST_CLEAR;
          load_s    = 1'b1;
          mode_s    = 1'b1;
          base_s    = {ADDR_W{1'b0}};
`endif
        end else begin
          err_n_s = 1'b1;
        end
      end
      ST_CELL: begin
        adv_s = 1'b1;
        if (last_s) begin
          state_n_s = ST_IDLE;
          done_n_s  = 1'b1;
        end else begin
          state_n_s = ST_CELL;
        end
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        adv_s = 1'b1;
        if (last_s) begin
          state_n_s = ST_IDLE;
          done_n_s  = 1'b1;
        end else begin
          state_n_s = ST_CLEAR;
        end
      end
`endif
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State and every registered output; reset forces all outputs to their idle values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      wr_r        <= 1'b0;
      clken_r     <= 1'b0;
      wdata_r     <= 16'h0000;
      be_r        <= 2'b00;
    end else begin
      state_r     <= state_n_s;
      cmd_ready_r <= (state_n_s == ST_IDLE);
      busy_r      <= (state_n_s != ST_IDLE);
      done_r      <= done_n_s;
      err_r       <= err_n_s;
      wr_r        <= (state_n_s != ST_IDLE);
      clken_r     <= 1'b1;
      be_r        <= (state_n_s != ST_IDLE) ? 2'b11 : 2'b00;
      if (load_s) begin
        wdata_r <= bus.cmd_color;
      end
    end
  end

  fb_addr_gen u_addr_gen (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .load  (load_s),
    .adv   (adv_s),
    .mode  (mode_s),
    .base  (base_s),
    .step  (ROW_STEP),
    .addr  (addr_s),
    .last  (last_s)
  );

  assign bus.cmd_ready       = cmd_ready_r;
  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.err             = err_r;
  assign bus.mem_chipselect  = wr_r;
  assign bus.mem_write       = wr_r;
  assign bus.mem_clken       = clken_r;
  assign bus.mem_address     = addr_s;
  assign bus.mem_writedata   = wdata_r;
  assign bus.mem_byteenable  = be_r;
  assign bus.mem_debugaccess = 1'b0;

endmodule

// File: tb/tb_fb_cell_painter.sv
// Self-checking bench for fb_cell_painter: directed and random commands against a
// pixel-level model of the expected write stream (honours FB_CLEAR_EN).
module tb_fb_cell_painter;
  import fb_pkg::*;

`ifdef FB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
    logic              cs;
  } wr_t;

  logic clk_clk       = 1'b0;
  logic reset_reset_n = 1'b0;
  int   cyc           = 0;
  int   total         = 0;
  int   bad           = 0;
  wr_t  wq[$];
  int   done_q[$];
  int   err_q[$];

  always #5 clk_clk = ~clk_clk;

  fb_cell_painter_if bus();

  fb_cell_painter dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus)
  );

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Monitor: every write beat and done/err pulse, stamped with the cycle index.
  always @(negedge clk_clk) begin
    if (bus.mem_write === 1'b1)
      wq.push_back('{cyc, bus.mem_address, bus.mem_writedata, bus.mem_byteenable, bus.mem_chipselect});
    if (bus.done === 1'b1) done_q.push_back(cyc);
    if (bus.err === 1'b1) err_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int op, input int cx, input int cy, input int color, output int acc);
    int n;
    n   = 0;
    acc = -1;
    @(negedge clk_clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_cx    = 6'(cx);
    bus.cmd_cy    = 5'(cy);
    bus.cmd_color = 16'(color);
    while (n < 400) begin
      if (bus.cmd_ready === 1'b1) begin
        @(posedge clk_clk);
        #1 acc = cyc;
        break;
      end
      @(negedge clk_clk);
      n++;
    end
    total++;
    assert (acc >= 0) else begin
      bad++;
      $error("FAIL accept_timeout observed=no_accept expected=accept op=%0d", op);
    end
  endtask

  task automatic drop();
    @(negedge clk_clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk_clk);
      n++;
      if (bus.busy === 1'b0 && bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk_clk);
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL idle_timeout observed=busy expected=idle within %0d cycles", budget);
    end
  endtask

  // Pops the expected burst (or err pulse) of one command from the monitor queues.
  task automatic check_burst(input int op, input int cx, input int cy, input int color, input int acc);
    bit  legal;
    int  n;
    int  exp_addr;
    int  dc;
    wr_t w;
    legal = (op == 0 && cx < GRID_W && cy < GRID_H) || (op == 1 && CLR_EN);
    if (!legal) begin
      dc = (err_q.size() > 0) ? err_q.pop_front() : -1;
      chk("err_cycle", dc, acc);
      return;
    end
    n = (op == 0) ? CELL * CELL : FB_PIX;
    for (int k = 0; k < n; k++) begin
      exp_addr = (op == 0) ? (cy * CELL + k / CELL) * FB_W + cx * CELL + k % CELL : k;
      total++;
      assert (wq.size() > 0) else begin
        bad++;
        $error("FAIL write_count observed=%0d expected=%0d", k, n);
        break;
      end
      w = wq.pop_front();
      chk("wr_addr", w.addr, exp_addr);
      chk("wr_data", w.data, color);
      chk("wr_be", w.be, 2'b11);
      chk("wr_cs", w.cs, 1'b1);
      chk("wr_cycle", w.cyc, acc + k);
    end
    dc = (done_q.size() > 0) ? done_q.pop_front() : -1;
    chk("done_cycle", dc, acc + n);
  endtask

  task automatic check_clean(input string tag);
    chk({tag, "_extra_writes"}, wq.size(), 0);
    chk({tag, "_extra_done"}, done_q.size(), 0);
    chk({tag, "_extra_err"}, err_q.size(), 0);
  endtask

  initial begin
    int acc;
    int acc2;
    int op;
    int cx;
    int cy;
    int col;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_cx    = 6'd0;
    bus.cmd_cy    = 5'd0;
    bus.cmd_color = 16'h0000;

    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_ready", bus.cmd_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_write", bus.mem_write, 1'b0);
    chk("rst_cs", bus.mem_chipselect, 1'b0);
    chk("rst_clken", bus.mem_clken, 1'b0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_data", bus.mem_writedata, 0);
    chk("rst_be", bus.mem_byteenable, 2'b00);
    chk("rst_done_err", {bus.done, bus.err, bus.mem_debugaccess}, 3'b000);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;
    chk("post_rst_ready", bus.cmd_ready, 1'b1);
    chk("post_rst_clken", bus.mem_clken, 1'b1);

    issue(0, 0, 0, 16'hF800, acc); drop(); wait_idle(200);
    check_burst(0, 0, 0, 16'hF800, acc); check_clean("cell00");

    issue(0, 39, 29, 16'h07E0, acc); drop(); wait_idle(200);
    check_burst(0, 39, 29, 16'h07E0, acc); check_clean("cell_corner");

    issue(0, 40, 0, 16'h1234, acc);
    chk("bad_cx_ready", bus.cmd_ready, 1'b1);
    chk("bad_cx_busy", bus.busy, 1'b0);
    drop(); wait_idle(50);
    check_burst(0, 40, 0, 16'h1234, acc); check_clean("bad_cx");

    issue(0, 3, 30, 16'h5555, acc); drop(); wait_idle(50);
    check_burst(0, 3, 30, 16'h5555, acc); check_clean("bad_cy");

    issue(2, 1, 1, 16'hAAAA, acc); drop(); wait_idle(50);
    check_burst(2, 1, 1, 16'hAAAA, acc); check_clean("bad_op");

    issue(1, 0, 0, 16'h0000, acc); drop(); wait_idle(FB_PIX + 200);
    check_burst(1, 0, 0, 16'h0000, acc); check_clean("clear");

    issue(0, 7, 4, 16'h1F1F, acc);
    issue(0, 8, 4, 16'hE0E0, acc2);
    drop(); wait_idle(300);
    chk("b2b_accept_cycle", acc2, acc + CELL * CELL + 1);
    check_burst(0, 7, 4, 16'h1F1F, acc);
    check_burst(0, 8, 4, 16'hE0E0, acc2);
    check_clean("b2b");

    for (int i = 0; i < 10; i++) begin
      op  = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 3) : 0;
      cx  = $urandom_range(0, 44);
      cy  = $urandom_range(0, 32);
      col = $urandom_range(0, 16'hFFFF);
      issue(op, cx, cy, col, acc); drop(); wait_idle(200);
      check_burst(op, cx, cy, col, acc); check_clean("rand");
    end

    issue(0, 5, 5, 16'h0F0F, acc); drop();
    for (int n = 0; n < 100 && wq.size() < 10; n++) @(negedge clk_clk);
    chk("mid_burst_writes", wq.size() >= 10, 1'b1);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("async_rst_write", bus.mem_write, 1'b0);
    chk("async_rst_cs", bus.mem_chipselect, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_ready", bus.cmd_ready, 1'b0);
    chk("async_rst_addr", bus.mem_address, 0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    wq.delete();
    done_q.delete();
    @(posedge clk_clk);
    #1;
    chk("rerst_ready", bus.cmd_ready, 1'b1);
    repeat (100) @(negedge clk_clk);
    check_clean("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
